// File: rtl/sodor_mem_pkg.sv
//----------------------------------------------------------------------
// sodor_mem_pkg: shared types and codes for the imem/dmem memory arbiter.
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

package sodor_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam logic       FCN_LD = 1'b0;
  localparam logic       FCN_ST = 1'b1;
  localparam logic [2:0] MT_W   = 3'd3;

endpackage

`default_nettype wire

// File: rtl/sodor_mem_prio_sel.sv
//----------------------------------------------------------------------
// sodor_mem_prio_sel: dmem-first 2-way select with imem starvation override.
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module sodor_mem_prio_sel
  import sodor_mem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic [3:0] starve_cnt_i,
  input  logic       imem_valid_i,
  input  logic       dmem_valid_i,
  output logic       any_valid_o,
  output owner_e     winner_o
);

  localparam logic [3:0] C_LIMIT = 4'(STARVE_LIMIT);

  logic w_force_i;

  assign w_force_i   = (starve_cnt_i == C_LIMIT) && imem_valid_i;
  assign any_valid_o = imem_valid_i | dmem_valid_i;

  always_comb begin
    winner_o = OWN_D;
    if (w_force_i || (imem_valid_i && !dmem_valid_i)) begin
      winner_o = OWN_I;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sodor_mem_arbiter.sv
//----------------------------------------------------------------------
// sodor_mem_arbiter: shares one single-ported memory between imem and dmem.
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module sodor_mem_arbiter
  import sodor_mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_imem_req_valid,
  output logic              io_imem_req_ready,
  input  logic [ADDR_W-1:0] io_imem_req_bits_addr,
  output logic              io_imem_resp_valid,
  output logic [DATA_W-1:0] io_imem_resp_bits_data,
  input  logic              io_dmem_req_valid,
  output logic              io_dmem_req_ready,
  input  logic [ADDR_W-1:0] io_dmem_req_bits_addr,
  input  logic [DATA_W-1:0] io_dmem_req_bits_data,
  input  logic              io_dmem_req_bits_fcn,
  input  logic [2:0]        io_dmem_req_bits_typ,
  output logic              io_dmem_resp_valid,
  output logic [DATA_W-1:0] io_dmem_resp_bits_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_bits_addr,
  output logic [DATA_W-1:0] mem_req_bits_data,
  output logic              mem_req_bits_fcn,
  output logic [2:0]        mem_req_bits_typ,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_bits_data,
  output logic              err_spurious
);

  localparam logic [3:0] C_LIMIT = 4'(STARVE_LIMIT);

  state_e     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       err_q, err_d;

  owner_e     w_winner;
  logic       w_any_valid;
  logic       w_idle;
  logic       w_handshake;

  sodor_mem_prio_sel #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_prio_sel (
    .starve_cnt_i (starve_q),
    .imem_valid_i (io_imem_req_valid),
    .dmem_valid_i (io_dmem_req_valid),
    .any_valid_o  (w_any_valid),
    .winner_o     (w_winner)
  );

  assign w_idle      = (state_q == ST_IDLE);
  assign w_handshake = w_idle && w_any_valid && mem_req_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      starve_q <= 4'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (w_handshake) begin
          state_d = (w_winner == OWN_I) ? ST_BUSY_I : ST_BUSY_D;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (mem_resp_valid) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Starvation count only moves while arbitrating; it holds across BUSY.
  always_comb begin
    starve_d = starve_q;
    if (w_idle) begin
      if (w_handshake && (w_winner == OWN_I)) begin
        starve_d = 4'd0;
      end else if (!io_imem_req_valid) begin
        starve_d = 4'd0;
      end else if (w_handshake) begin
        starve_d = (starve_q >= C_LIMIT) ? C_LIMIT : starve_q + 4'd1;
      end
    end
  end

  assign err_d        = err_q | (w_idle & mem_resp_valid);
  assign err_spurious = err_q;

  always_comb begin
    io_imem_req_ready      = 1'b0;
    io_dmem_req_ready      = 1'b0;
    io_imem_resp_valid     = 1'b0;
    io_imem_resp_bits_data = '0;
    io_dmem_resp_valid     = 1'b0;
    io_dmem_resp_bits_data = '0;
    mem_req_valid          = 1'b0;
    mem_req_bits_addr      = '0;
    mem_req_bits_data      = '0;
    mem_req_bits_fcn       = FCN_LD;
    mem_req_bits_typ       = 3'd0;
    case (state_q)
      ST_IDLE: begin
        mem_req_valid = w_any_valid;
        if (w_any_valid) begin
          if (w_winner == OWN_I) begin
            io_imem_req_ready = mem_req_ready;
            mem_req_bits_addr = io_imem_req_bits_addr;
            mem_req_bits_typ  = MT_W;
          end else begin
            io_dmem_req_ready = mem_req_ready;
            mem_req_bits_addr = io_dmem_req_bits_addr;
            mem_req_bits_data = io_dmem_req_bits_data;
            mem_req_bits_fcn  = io_dmem_req_bits_fcn;
            mem_req_bits_typ  = io_dmem_req_bits_typ;
          end
        end
      end
      ST_BUSY_I: begin
        if (mem_resp_valid) begin
          io_imem_resp_valid     = 1'b1;
          io_imem_resp_bits_data = mem_resp_bits_data;
        end
      end
      ST_BUSY_D: begin
        if (mem_resp_valid) begin
          io_dmem_resp_valid     = 1'b1;
          io_dmem_resp_bits_data = mem_resp_bits_data;
        end
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire
